// File: rtl/tmr0_wdt_ctrl_pkg.sv
// Shared definitions for the TMR0 / watchdog sequencer: OPTION field layout,
// reset value and the sleep state encoding.
package tmr0_wdt_ctrl_pkg;

  localparam int unsigned OPT_W    = 6;
  localparam int unsigned PS_W     = 3;
  localparam int unsigned T0CS_BIT = 5;
  localparam int unsigned T0SE_BIT = 4;
  localparam int unsigned PSA_BIT  = 3;
  localparam int unsigned PS_MSB   = 2;
  localparam int unsigned PS_LSB   = 0;
  localparam int unsigned INH_W    = 2;

  localparam logic [OPT_W-1:0] OPTION_RST = 6'h3F;

  typedef struct packed {
    logic            t0cs;
    logic            t0se;
    logic            psa;
    logic [PS_W-1:0] ps;
  } option_t;

  typedef enum logic {
    AWAKE  = 1'b0,
    ASLEEP = 1'b1
  } sleep_state_e;

endpackage

// File: rtl/tmr0_wdt_ctrl_t0cki_sync.sv
// Brings the asynchronous T0CKI pin into the clk domain and flags the
// selected edge (rising when t0se_i=0, falling when t0se_i=1).
module t0cki_sync
  import tmr0_wdt_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t0cki_i,
  input  logic t0se_i,
  output logic edge_c_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-stage synchroniser plus one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= t0cki_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  always_comb begin
    edge_c_o = 1'b0;
    if (t0se_i) edge_c_o = prev_q & ~sync_q;
    else        edge_c_o = sync_q & ~prev_q;
  end

endmodule

// File: rtl/tmr0_wdt_ctrl.sv
// TMR0 / watchdog sequencer: OPTION register, shared prescaler, watchdog
// counter and sleep state, producing tmr0_inc / wdtmr strobes and TO_N/PD_N.
module tmr0_wdt_ctrl
  import tmr0_wdt_ctrl_pkg::*;
#(
  parameter int unsigned WDT_BITS = 10,
  parameter int unsigned PS_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       option_wr,
  input  logic [5:0] option_in,
  input  logic       tmr0_wr,
  input  logic       t0cki,
  input  logic       wdt_en,
  input  logic       clrwdt,
  input  logic       sleep,
  output logic [5:0] option_q,
  output logic       tmr0_inc,
  output logic       wdtmr,
  output logic       wake,
  output logic       asleep,
  output logic       to_n,
  output logic       pd_n
);

  sleep_state_e        state_q, state_d;
  logic [OPT_W-1:0]    option_d;
  logic [PS_BITS-1:0]  ps_q, ps_d;
  logic [WDT_BITS-1:0] wdt_q, wdt_d;
  logic [INH_W-1:0]    inh_q, inh_d;
  logic                tmr0_inc_q, tmr0_inc_d;
  logic                wdtmr_q, wdtmr_d;
  logic                wake_q, wake_d;
  logic                to_n_q, to_n_d;
  logic                pd_n_q, pd_n_d;

  option_t             opt;
  logic                awake;
  logic                opt_wr_a, tmr0_wr_a, clrwdt_a, sleep_a, wdt_clr_a;
  logic                ext_edge;
  logic                tmr0_ev;
  logic                wdt_tick;
  logic [PS_BITS-1:0]  ps_inc;
  logic                ps_fall;
  logic                ps_clr;
  logic                timeout;

  assign opt   = option_t'(option_q);
  assign awake = (state_q == AWAKE);

  // Core-driven strobes are ignored during power-down
  assign opt_wr_a  = option_wr & awake;
  assign tmr0_wr_a = tmr0_wr & awake;
  assign clrwdt_a  = clrwdt & awake;
  assign sleep_a   = sleep & awake;
  assign wdt_clr_a = clrwdt_a | sleep_a;

  t0cki_sync u_t0cki_sync (
    .clk      (clk),
    .rst      (rst),
    .t0cki_i  (t0cki),
    .t0se_i   (opt.t0se),
    .edge_c_o (ext_edge)
  );

  // Count events and prescaler/watchdog datapath
  always_comb begin
    tmr0_ev    = 1'b0;
    wdt_tick   = 1'b0;
    ps_inc     = ps_q + PS_BITS'(1);
    ps_fall    = 1'b0;
    ps_clr     = 1'b0;
    timeout    = 1'b0;
    ps_d       = ps_q;
    wdt_d      = wdt_q;
    inh_d      = inh_q;
    option_d   = option_q;
    tmr0_inc_d = 1'b0;

    // Internal clock stops in sleep; pin edges keep counting
    tmr0_ev = (opt.t0cs ? ext_edge : awake) & ~tmr0_wr_a & (inh_q == INH_W'(0));

    wdt_tick = wdt_en & (wdt_q == {WDT_BITS{1'b1}});
    ps_fall  = ps_q[opt.ps] & ~ps_inc[opt.ps];

    ps_clr = (opt_wr_a & (option_in[PSA_BIT] != opt.psa))
           | (tmr0_wr_a & ~opt.psa)
           | (wdt_clr_a & opt.psa);

    if (ps_clr)
      ps_d = '0;
    else if (opt.psa ? wdt_tick : tmr0_ev)
      ps_d = ps_inc;

    if (opt.psa) begin
      tmr0_inc_d = tmr0_ev & awake;
      timeout    = wdt_tick & ps_fall;
    end else begin
      tmr0_inc_d = tmr0_ev & ps_fall & awake;
      timeout    = wdt_tick;
    end

    if (!wdt_en || wdt_clr_a)
      wdt_d = '0;
    else
      wdt_d = wdt_q + WDT_BITS'(1);

    if (tmr0_wr_a)
      inh_d = INH_W'(2);
    else if (inh_q != INH_W'(0))
      inh_d = inh_q - INH_W'(1);

    if (opt_wr_a)
      option_d = option_in;
  end

  // Sleep FSM and status bits; SLEEP beats CLRWDT, both beat a timeout
  always_comb begin
    state_d = state_q;
    wdtmr_d = 1'b0;
    wake_d  = 1'b0;
    to_n_d  = to_n_q;
    pd_n_d  = pd_n_q;
    case (state_q)
      AWAKE: begin
        if (sleep_a) begin
          state_d = ASLEEP;
          to_n_d  = 1'b1;
          pd_n_d  = 1'b0;
        end else if (clrwdt_a) begin
          to_n_d  = 1'b1;
          pd_n_d  = 1'b1;
        end else if (timeout) begin
          wdtmr_d = 1'b1;
          to_n_d  = 1'b0;
        end
      end
      ASLEEP: begin
        if (timeout) begin
          state_d = AWAKE;
          wdtmr_d = 1'b1;
          wake_d  = 1'b1;
          to_n_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= AWAKE;
      option_q   <= OPTION_RST;
      ps_q       <= '0;
      wdt_q      <= '0;
      inh_q      <= '0;
      tmr0_inc_q <= 1'b0;
      wdtmr_q    <= 1'b0;
      wake_q     <= 1'b0;
      to_n_q     <= 1'b1;
      pd_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      option_q   <= option_d;
      ps_q       <= ps_d;
      wdt_q      <= wdt_d;
      inh_q      <= inh_d;
      tmr0_inc_q <= tmr0_inc_d;
      wdtmr_q    <= wdtmr_d;
      wake_q     <= wake_d;
      to_n_q     <= to_n_d;
      pd_n_q     <= pd_n_d;
    end
  end

  assign tmr0_inc = tmr0_inc_q;
  assign wdtmr    = wdtmr_q;
  assign wake     = wake_q;
  assign asleep   = (state_q == ASLEEP);
  assign to_n     = to_n_q;
  assign pd_n     = pd_n_q;

endmodule

// File: tb/tb_tmr0_wdt_ctrl.sv
// Scoreboard bench for tmr0_wdt_ctrl: stimulus queues expected pulse cycles and
// status snapshots; a negedge monitor pops and compares them.
module tb_tmr0_wdt_ctrl;
  import tmr0_wdt_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       option_wr = 1'b0;
  logic [5:0] option_in = 6'h00;
  logic       tmr0_wr = 1'b0;
  logic       t0cki = 1'b0;
  logic       wdt_en = 1'b0;
  logic       clrwdt = 1'b0;
  logic       sleep = 1'b0;
  logic [5:0] option_q;
  logic       tmr0_inc, wdtmr, wake, asleep, to_n, pd_n;

  tmr0_wdt_ctrl #(.WDT_BITS(4), .PS_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .option_wr (option_wr),
    .option_in (option_in),
    .tmr0_wr   (tmr0_wr),
    .t0cki     (t0cki),
    .wdt_en    (wdt_en),
    .clrwdt    (clrwdt),
    .sleep     (sleep),
    .option_q  (option_q),
    .tmr0_inc  (tmr0_inc),
    .wdtmr     (wdtmr),
    .wake      (wake),
    .asleep    (asleep),
    .to_n      (to_n),
    .pd_n      (pd_n)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int         exp_inc[$];
  int         exp_wdt[$];
  int         exp_wake[$];
  int         stat_cyc[$];
  logic [8:0] stat_exp[$];
  string      stat_nm[$];
  int         n_chk = 0;
  int         n_fail = 0;

  int         e_m;
  int         c_m;
  logic [8:0] x_m;
  logic [8:0] a_m;
  string      s_m;

  // Monitor: compares DUT pulses and status against the queued expectations
  always @(negedge clk) begin
    if (!rst) begin
      if (tmr0_inc) begin
        n_chk++;
        if (exp_inc.size() == 0) begin
          n_fail++;
          $display("FAIL tmr0_inc: unexpected pulse at cycle %0d", cyc);
        end else begin
          e_m = exp_inc.pop_front();
          if (e_m != cyc) begin
            n_fail++;
            $display("FAIL tmr0_inc: pulse at cycle %0d, expected cycle %0d", cyc, e_m);
          end
        end
      end else if (exp_inc.size() != 0 && exp_inc[0] <= cyc) begin
        n_chk++; n_fail++;
        e_m = exp_inc.pop_front();
        $display("FAIL tmr0_inc: no pulse at cycle %0d, expected cycle %0d", cyc, e_m);
      end

      if (wdtmr) begin
        n_chk++;
        if (exp_wdt.size() == 0) begin
          n_fail++;
          $display("FAIL wdtmr: unexpected pulse at cycle %0d", cyc);
        end else begin
          e_m = exp_wdt.pop_front();
          if (e_m != cyc) begin
            n_fail++;
            $display("FAIL wdtmr: pulse at cycle %0d, expected cycle %0d", cyc, e_m);
          end
        end
      end else if (exp_wdt.size() != 0 && exp_wdt[0] <= cyc) begin
        n_chk++; n_fail++;
        e_m = exp_wdt.pop_front();
        $display("FAIL wdtmr: no pulse at cycle %0d, expected cycle %0d", cyc, e_m);
      end

      if (wake) begin
        n_chk++;
        if (exp_wake.size() == 0) begin
          n_fail++;
          $display("FAIL wake: unexpected pulse at cycle %0d", cyc);
        end else begin
          e_m = exp_wake.pop_front();
          if (e_m != cyc) begin
            n_fail++;
            $display("FAIL wake: pulse at cycle %0d, expected cycle %0d", cyc, e_m);
          end
        end
      end else if (exp_wake.size() != 0 && exp_wake[0] <= cyc) begin
        n_chk++; n_fail++;
        e_m = exp_wake.pop_front();
        $display("FAIL wake: no pulse at cycle %0d, expected cycle %0d", cyc, e_m);
      end

      a_m = {option_q, asleep, to_n, pd_n};
      while (stat_cyc.size() != 0 && stat_cyc[0] <= cyc) begin
        c_m = stat_cyc.pop_front();
        x_m = stat_exp.pop_front();
        s_m = stat_nm.pop_front();
        n_chk++;
        if (c_m != cyc || a_m != x_m) begin
          n_fail++;
          $display("FAIL %s: cycle %0d {option,asleep,to_n,pd_n} actual=%h expected=%h (due cycle %0d)",
                   s_m, cyc, a_m, x_m, c_m);
        end
      end
    end
  end

  task automatic exp_stat(input int c, input logic [5:0] opt, input logic a,
                          input logic t, input logic p, input string nm);
    stat_cyc.push_back(c);
    stat_exp.push_back({opt, a, t, p});
    stat_nm.push_back(nm);
  endtask

  task automatic exp_inc_range(input int first, input int last, input int step);
    for (int c = first; c <= last; c += step) exp_inc.push_back(c);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    option_wr = 1'b0;
    option_in = 6'h00;
    tmr0_wr   = 1'b0;
    t0cki     = 1'b0;
    clrwdt    = 1'b0;
    sleep     = 1'b0;
  endtask

  // Leaves the bench at the start of cycle 0, just after a clock edge
  task automatic do_reset(input logic we);
    rst = 1'b1;
    clear_inputs();
    wdt_en = we;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_drained(input string nm, input int n);
    n_chk++;
    if (n != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected events still pending, expected 0", nm, n);
    end
  endtask

  task automatic end_test(input string nm);
    @(negedge clk);
    #1;
    chk_drained({nm, " tmr0_inc queue"}, exp_inc.size());
    chk_drained({nm, " wdtmr queue"}, exp_wdt.size());
    chk_drained({nm, " wake queue"}, exp_wake.size());
    chk_drained({nm, " status queue"}, stat_cyc.size());
    exp_inc.delete();
    exp_wdt.delete();
    exp_wake.delete();
    stat_cyc.delete();
    stat_exp.delete();
    stat_nm.delete();
    rst = 1'b1;
    clear_inputs();
  endtask

  task automatic write_option(input logic [5:0] v);
    option_wr = 1'b1;
    option_in = v;
    wait_cyc(cyc + 1);
    option_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    // Internal clock, PSA=0: 1:2 then 1:256
    do_reset(1'b0);
    exp_stat(0, OPTION_RST, 1'b0, 1'b1, 1'b1, "reset_state");
    exp_stat(1, 6'h00, 1'b0, 1'b1, 1'b1, "option_00");
    exp_stat(21, 6'h07, 1'b0, 1'b1, 1'b1, "option_07");
    exp_inc_range(3, 21, 2);
    exp_inc.push_back(257);
    exp_inc.push_back(513);
    write_option(6'h00);
    wait_cyc(20);
    write_option(6'h07);
    wait_cyc(520);
    end_test("t1");

    // TMR0 write inhibit with 1:4 prescale
    do_reset(1'b0);
    exp_inc.push_back(5);
    exp_inc.push_back(9);
    exp_inc.push_back(17);
    exp_inc.push_back(21);
    write_option(6'h01);
    wait_cyc(10);
    tmr0_wr = 1'b1;
    wait_cyc(11);
    tmr0_wr = 1'b0;
    wait_cyc(24);
    end_test("t2");

    // External clock through the synchroniser, rising then falling edges
    do_reset(1'b0);
    exp_inc_range(8, 40, 8);
    exp_stat(46, 6'h38, 1'b0, 1'b1, 1'b1, "option_38");
    exp_inc.push_back(57);
    exp_inc.push_back(67);
    write_option(6'h28);
    for (int k = 0; k < 5; k++) begin
      wait_cyc(5 + 8 * k);
      t0cki = 1'b1;
      wait_cyc(9 + 8 * k);
      t0cki = 1'b0;
    end
    wait_cyc(45);
    write_option(6'h38);
    for (int k = 0; k < 2; k++) begin
      wait_cyc(50 + 10 * k);
      t0cki = 1'b1;
      wait_cyc(54 + 10 * k);
      t0cki = 1'b0;
    end
    wait_cyc(70);
    end_test("t3");

    // Watchdog timeout at 32 cycles, CLRWDT on the timeout cycle blocks it
    do_reset(1'b1);
    exp_inc_range(2, 100, 1);
    exp_wdt.push_back(32);
    exp_wdt.push_back(96);
    exp_stat(31, 6'h08, 1'b0, 1'b1, 1'b1, "before_timeout");
    exp_stat(32, 6'h08, 1'b0, 1'b0, 1'b1, "timeout_to_n");
    exp_stat(64, 6'h08, 1'b0, 1'b1, 1'b1, "clrwdt_beats_timeout");
    exp_stat(96, 6'h08, 1'b0, 1'b0, 1'b1, "timeout_after_clrwdt");
    write_option(6'h08);
    wait_cyc(63);
    clrwdt = 1'b1;
    wait_cyc(64);
    clrwdt = 1'b0;
    wait_cyc(100);
    end_test("t4");

    // SLEEP, ignored strobes while asleep, WDT wake
    do_reset(1'b1);
    exp_inc_range(2, 11, 1);
    exp_inc_range(44, 50, 1);
    exp_wdt.push_back(43);
    exp_wake.push_back(43);
    exp_stat(11, 6'h08, 1'b1, 1'b1, 1'b0, "sleep_entry");
    exp_stat(22, 6'h08, 1'b1, 1'b1, 1'b0, "ignored_while_asleep");
    exp_stat(42, 6'h08, 1'b1, 1'b1, 1'b0, "still_asleep");
    exp_stat(43, 6'h08, 1'b0, 1'b0, 1'b0, "wake_status");
    write_option(6'h08);
    wait_cyc(10);
    sleep = 1'b1;
    wait_cyc(11);
    sleep = 1'b0;
    wait_cyc(20);
    clrwdt = 1'b1;
    wait_cyc(21);
    clrwdt = 1'b0;
    write_option(6'h00);
    wait_cyc(50);
    end_test("t5");

    // Asynchronous reset in the middle of sleep
    do_reset(1'b1);
    exp_inc_range(2, 6, 1);
    exp_stat(6, 6'h08, 1'b1, 1'b1, 1'b0, "asleep_before_rst");
    write_option(6'h08);
    wait_cyc(5);
    sleep = 1'b1;
    wait_cyc(6);
    sleep = 1'b0;
    wait_cyc(15);
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({option_q, asleep, to_n, pd_n, tmr0_inc, wdtmr, wake} !== {OPTION_RST, 6'b011000}) begin
      n_fail++;
      $display("FAIL async_reset: {option,asleep,to_n,pd_n,inc,wdtmr,wake} actual=%h expected=%h",
               {option_q, asleep, to_n, pd_n, tmr0_inc, wdtmr, wake}, {OPTION_RST, 6'b011000});
    end
    end_test("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
